bist_session_sequencer: RTL and testbench
=========================================

# bist_session_sequencer

Multi-configuration session scheduler for the STUMPS adding-CPU BIST datapath. It sits above the STUMPS controller, PRPGs and MISRs. It holds a small table of polynomial/golden-signature configurations and, per configuration, drives the LFSR/MISR polynomials and issues a session reset to the STUMPS controller. It then waits for that session's `done`, compares both MISR signatures against the golden values, and accumulates a per-configuration pass/fail map, replacing the testbench-side configuration/signature file loop with hardware.

## Interface
Parameters:
- NUM_CFG, 4, number of table entries; all run per start, in order 0..NUM_CFG-1
- PRPG1_Size, 16, width of PRPG1 polynomial
- PRPG2_Size, 12, width of PRPG2 polynomial
- MISR1_Size, 16, width of MISR1 polynomial/signature
- MISR2_Size, 12, width of MISR2 polynomial/signature
- TIMEOUT, 4095, maximum RUN cycles before a session is declared failed

Ports:
- clk  in  1  single clock, posedge
- masterRst  in  1  asynchronous, active-high reset
- start  in  1  begin a sequence; sampled only in IDLE or FINISH
- cfgWe  in  1  table write strobe; ignored while busy
- cfgAddr  in  $clog2(NUM_CFG)  entry index
- cfgField  in  3  0 PRPG1 poly, 1 PRPG2 poly, 2 MISR1 poly, 3 MISR2 poly, 4 golden MISR1, 5 golden MISR2; 6/7 ignored
- cfgData  in  16  field value; narrower fields take low bits
- stumpsDone  in  1  `done` from STUMPS controller
- MISR1_Out  in  MISR1_Size  live MISR1 signature
- MISR2_Out  in  MISR2_Size  live MISR2 signature
- sessRst  out  1  one-cycle reset pulse to STUMPS controller masterRst input
- PRPG1_Poly / PRPG2_Poly / MISR1_Poly / MISR2_Poly  out  sized  registered polynomials for current entry
- cfgIdx  out  $clog2(NUM_CFG)  entry under test
- busy  out  1  high from LOAD through CHECK
- done  out  1  level; high in FINISH until next start
- pass  out  1  valid with done; 1 iff failMap is all zero
- failMap  out  NUM_CFG  bit i set if entry i miscompared or timed out
- timeoutErr  out  1  sticky; set if any session hit TIMEOUT

## Operation
- States: IDLE, LOAD, RST, RUN, CHECK, FINISH.
- IDLE/FINISH + start → LOAD:
  - cfgIdx←0, failMap←0, timeoutErr←0, done←0.
- LOAD: the four polynomial outputs are registered from table[cfgIdx] → RST.
- RST: sessRst=1 for exactly this one cycle; timeout counter←0 → RUN.
- RUN: doneEdge = stumpsDone & ~stumpsDone_q, where stumpsDone_q is registered every cycle.
  - On doneEdge → CHECK.
  - If the counter reaches TIMEOUT first: failMap[cfgIdx]←1, timeoutErr←1, then the CHECK exit path is taken without comparing.
  - A level-high stumpsDone carried over from the previous session is not an edge.
- CHECK: if {MISR1_Out, MISR2_Out} ≠ golden pair of entry cfgIdx, failMap[cfgIdx]←1.
  - If cfgIdx = NUM_CFG-1 → FINISH (done←1).
  - Otherwise cfgIdx+1 → LOAD.
- Table writes are accepted only when not busy. A write and a start in the same cycle: the write lands first, and that entry is used.
- Start while busy is ignored.
- masterRst, asserted at any time including mid-session, asynchronously returns everything to IDLE. Reset values:
  - all table fields, polynomial outputs, cfgIdx, failMap: 0
  - busy, done, pass, timeoutErr, sessRst: 0
- Top level ORs masterRst into the STUMPS controller reset alongside sessRst.

## Timing
- Edge 0 samples start → LOAD in cycle 1, RST in cycle 2 (sessRst high), RUN from cycle 3.
- Polynomials are stable from cycle 2 until the next LOAD. They never change during RST/RUN/CHECK.
- stumpsDone rising in cycle k is seen as doneEdge in cycle k → CHECK in k+1. Compare uses MISR values in cycle k+1; the STUMPS controller holds signatures after done.
- Per-entry overhead: 4 cycles (LOAD, RST, CHECK, plus edge detect) plus the session length.
- Timeout: exactly TIMEOUT RUN cycles without an edge forces the fail path.
- The timeout counter is $clog2(TIMEOUT+1) bits, saturating, and cleared in RST.

## Structure
- Package bist_seq_pkg: state enum, cfgField codes (FLD_PRPG1 … FLD_GOLD2).
- Sub-module bist_cfg_table: NUM_CFG-entry register file with field write port and full-entry read at cfgIdx, async reset to 0.
- FSM, edge detector, timeout counter and compare live in the top.

## Test plan
- Load 4 entries whose golden values match a behavioural STUMPS model; start → done after 4 sessions, pass=1, failMap=4'b0000, exactly 4 single-cycle sessRst pulses.
- Corrupt golden MISR2 of entry 2 by one bit → failMap=4'b0100, pass=0, timeoutErr=0.
- Model never raises stumpsDone for entry 1 → RUN lasts exactly 4095 cycles, failMap[1]=1, timeoutErr=1, sequence continues to entries 2–3.
- Hold stumpsDone high across the LOAD→RUN boundary → no early CHECK; only a fresh rising edge advances.
- Assert masterRst mid-RUN of entry 3 → all outputs and table 0 immediately; a later start with an empty table runs with zero polynomials.
- cfgWe and start while busy → table unchanged, sequence unaffected; cfgWe+start in the same IDLE cycle → new value used for that entry.

Source files
------------

// File: rtl/bist_seq_pkg.sv
// Shared constants for the BIST session sequencer: FSM state codes and
// configuration-table field selectors.
package bist_seq_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RST    = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  // Table field selectors (codes 6 and 7 write nothing)
  localparam logic [2:0] FLD_PRPG1 = 3'd0;
  localparam logic [2:0] FLD_PRPG2 = 3'd1;
  localparam logic [2:0] FLD_MISR1 = 3'd2;
  localparam logic [2:0] FLD_MISR2 = 3'd3;
  localparam logic [2:0] FLD_GOLD1 = 3'd4;
  localparam logic [2:0] FLD_GOLD2 = 3'd5;

endpackage

// File: rtl/bist_cfg_table.sv
// Configuration table: NUM_CFG entries of four polynomials plus two golden
// signatures. Single field-wide write port, full-entry combinational read.
module bist_cfg_table
  import bist_seq_pkg::*;
#(
  parameter int NUM_CFG    = 4,
  parameter int PRPG1_Size = 16,
  parameter int PRPG2_Size = 12,
  parameter int MISR1_Size = 16,
  parameter int MISR2_Size = 12
) (
  input  logic                        clk,
  input  logic                        masterRst,
  input  logic                        we,
  input  logic [$clog2(NUM_CFG)-1:0]  addr,
  input  logic [2:0]                  field,
  input  logic [15:0]                 data,
  input  logic [$clog2(NUM_CFG)-1:0]  rd_addr,
  output logic [PRPG1_Size-1:0]       prpg1_rd,
  output logic [PRPG2_Size-1:0]       prpg2_rd,
  output logic [MISR1_Size-1:0]       misr1_rd,
  output logic [MISR2_Size-1:0]       misr2_rd,
  output logic [MISR1_Size-1:0]       gold1_rd,
  output logic [MISR2_Size-1:0]       gold2_rd
);

  logic [PRPG1_Size-1:0] prpg1_mem [NUM_CFG];
  logic [PRPG2_Size-1:0] prpg2_mem [NUM_CFG];
  logic [MISR1_Size-1:0] misr1_mem [NUM_CFG];
  logic [MISR2_Size-1:0] misr2_mem [NUM_CFG];
  logic [MISR1_Size-1:0] gold1_mem [NUM_CFG];
  logic [MISR2_Size-1:0] gold2_mem [NUM_CFG];

  // Field write; narrower fields keep the low bits of data
  always_ff @(posedge clk or posedge masterRst) begin
    if (masterRst) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        prpg1_mem[i] <= '0;
        prpg2_mem[i] <= '0;
        misr1_mem[i] <= '0;
        misr2_mem[i] <= '0;
        gold1_mem[i] <= '0;
        gold2_mem[i] <= '0;
      end
    end else if (we) begin
      case (field)
        FLD_PRPG1: prpg1_mem[addr] <= PRPG1_Size'(data);
        FLD_PRPG2: prpg2_mem[addr] <= PRPG2_Size'(data);
        FLD_MISR1: misr1_mem[addr] <= MISR1_Size'(data);
        FLD_MISR2: misr2_mem[addr] <= MISR2_Size'(data);
        FLD_GOLD1: gold1_mem[addr] <= MISR1_Size'(data);
        FLD_GOLD2: gold2_mem[addr] <= MISR2_Size'(data);
        default: ;
      endcase
    end
  end

  assign prpg1_rd = prpg1_mem[rd_addr];
  assign prpg2_rd = prpg2_mem[rd_addr];
  assign misr1_rd = misr1_mem[rd_addr];
  assign misr2_rd = misr2_mem[rd_addr];
  assign gold1_rd = gold1_mem[rd_addr];
  assign gold2_rd = gold2_mem[rd_addr];

endmodule

// File: rtl/bist_session_sequencer.sv
// BIST session sequencer: walks every table entry, loads its polynomials,
// pulses the STUMPS session reset, waits for a fresh done edge (or timeout),
// compares both MISR signatures with the golden pair and builds a fail map.
// sessRst is the pure session pulse; the integration level ORs masterRst in.
module bist_session_sequencer
  import bist_seq_pkg::*;
#(
  parameter int NUM_CFG    = 4,
  parameter int PRPG1_Size = 16,
  parameter int PRPG2_Size = 12,
  parameter int MISR1_Size = 16,
  parameter int MISR2_Size = 12,
  parameter int TIMEOUT    = 4095
) (
  input  logic                        clk,
  input  logic                        masterRst,
  input  logic                        start,
  input  logic                        cfgWe,
  input  logic [$clog2(NUM_CFG)-1:0]  cfgAddr,
  input  logic [2:0]                  cfgField,
  input  logic [15:0]                 cfgData,
  input  logic                        stumpsDone,
  input  logic [MISR1_Size-1:0]       MISR1_Out,
  input  logic [MISR2_Size-1:0]       MISR2_Out,
  output logic                        sessRst,
  output logic [PRPG1_Size-1:0]       PRPG1_Poly,
  output logic [PRPG2_Size-1:0]       PRPG2_Poly,
  output logic [MISR1_Size-1:0]       MISR1_Poly,
  output logic [MISR2_Size-1:0]       MISR2_Poly,
  output logic [$clog2(NUM_CFG)-1:0]  cfgIdx,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [NUM_CFG-1:0]          failMap,
  output logic                        timeoutErr
);

  localparam int IW = $clog2(NUM_CFG);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]            state_reg;
  logic [IW-1:0]         cfg_idx_reg;
  logic [NUM_CFG-1:0]    fail_map_reg;
  logic                  timeout_err_reg;
  logic                  timed_out_reg;
  logic [TW-1:0]         tmo_cnt_reg;
  logic                  stumps_done_q;
  logic                  done_edge;
  logic                  table_we;

  logic [PRPG1_Size-1:0] prpg1_reg, tbl_prpg1;
  logic [PRPG2_Size-1:0] prpg2_reg, tbl_prpg2;
  logic [MISR1_Size-1:0] misr1_reg, tbl_misr1, tbl_gold1;
  logic [MISR2_Size-1:0] misr2_reg, tbl_misr2, tbl_gold2;

  assign busy     = (state_reg == ST_LOAD) || (state_reg == ST_RST) ||
                    (state_reg == ST_RUN)  || (state_reg == ST_CHECK);
  assign table_we = cfgWe & ~busy;

  bist_cfg_table #(
    .NUM_CFG   (NUM_CFG),
    .PRPG1_Size(PRPG1_Size),
    .PRPG2_Size(PRPG2_Size),
    .MISR1_Size(MISR1_Size),
    .MISR2_Size(MISR2_Size)
  ) u_table (
    .clk      (clk),
    .masterRst(masterRst),
    .we       (table_we),
    .addr     (cfgAddr),
    .field    (cfgField),
    .data     (cfgData),
    .rd_addr  (cfg_idx_reg),
    .prpg1_rd (tbl_prpg1),
    .prpg2_rd (tbl_prpg2),
    .misr1_rd (tbl_misr1),
    .misr2_rd (tbl_misr2),
    .gold1_rd (tbl_gold1),
    .gold2_rd (tbl_gold2)
  );

  // Delayed copy of stumpsDone so only a fresh rising edge ends a session
  always_ff @(posedge clk or posedge masterRst) begin
    if (masterRst) stumps_done_q <= 1'b0;
    else           stumps_done_q <= stumpsDone;
  end

  assign done_edge = stumpsDone & ~stumps_done_q;

  // Session FSM with timeout counter, compare and fail-map accumulation
  always_ff @(posedge clk or posedge masterRst) begin
    if (masterRst) begin
      state_reg       <= ST_IDLE;
      cfg_idx_reg     <= '0;
      fail_map_reg    <= '0;
      timeout_err_reg <= 1'b0;
      timed_out_reg   <= 1'b0;
      tmo_cnt_reg     <= '0;
      prpg1_reg       <= '0;
      prpg2_reg       <= '0;
      misr1_reg       <= '0;
      misr2_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            state_reg       <= ST_LOAD;
            cfg_idx_reg     <= '0;
            fail_map_reg    <= '0;
            timeout_err_reg <= 1'b0;
          end
        end
        ST_LOAD: begin
          prpg1_reg <= tbl_prpg1;
          prpg2_reg <= tbl_prpg2;
          misr1_reg <= tbl_misr1;
          misr2_reg <= tbl_misr2;
          state_reg <= ST_RST;
        end
        ST_RST: begin
          tmo_cnt_reg   <= '0;
          timed_out_reg <= 1'b0;
          state_reg     <= ST_RUN;
        end
        ST_RUN: begin
          if (done_edge) begin
            state_reg <= ST_CHECK;
          end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
            // Last allowed RUN cycle without an edge: fail without comparing
            fail_map_reg[cfg_idx_reg] <= 1'b1;
            timeout_err_reg           <= 1'b1;
            timed_out_reg             <= 1'b1;
            state_reg                 <= ST_CHECK;
          end else if (tmo_cnt_reg != {TW{1'b1}}) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_CHECK: begin
          if (!timed_out_reg && ({MISR1_Out, MISR2_Out} != {tbl_gold1, tbl_gold2}))
            fail_map_reg[cfg_idx_reg] <= 1'b1;
          if (cfg_idx_reg == IW'(NUM_CFG - 1)) begin
            state_reg <= ST_FINISH;
          end else begin
            cfg_idx_reg <= cfg_idx_reg + 1'b1;
            state_reg   <= ST_LOAD;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sessRst    = (state_reg == ST_RST);
  assign done       = (state_reg == ST_FINISH);
  assign pass       = done & ~(|fail_map_reg);
  assign failMap    = fail_map_reg;
  assign timeoutErr = timeout_err_reg;
  assign cfgIdx     = cfg_idx_reg;
  assign PRPG1_Poly = prpg1_reg;
  assign PRPG2_Poly = prpg2_reg;
  assign MISR1_Poly = misr1_reg;
  assign MISR2_Poly = misr2_reg;

endmodule

// File: tb/tb_bist_session_sequencer.sv
// Testbench for bist_session_sequencer: a behavioural STUMPS model produces
// signatures from the driven polynomials; expectations come from a shadow
// copy of the configuration table.
module tb_bist_session_sequencer;

  localparam int N  = 4;
  localparam int TO = 4095;

  logic        clk = 1'b0;
  logic        masterRst = 1'b1;
  logic        start = 1'b0;
  logic        cfgWe = 1'b0;
  logic [1:0]  cfgAddr = '0;
  logic [2:0]  cfgField = '0;
  logic [15:0] cfgData = '0;
  logic        stumpsDone = 1'b0;
  logic [15:0] MISR1_Out = '0;
  logic [11:0] MISR2_Out = '0;
  logic        sessRst;
  logic [15:0] PRPG1_Poly;
  logic [11:0] PRPG2_Poly;
  logic [15:0] MISR1_Poly;
  logic [11:0] MISR2_Poly;
  logic [1:0]  cfgIdx;
  logic        busy, done, pass, timeoutErr;
  logic [N-1:0] failMap;

  bist_session_sequencer #(
    .NUM_CFG(N), .PRPG1_Size(16), .PRPG2_Size(12),
    .MISR1_Size(16), .MISR2_Size(12), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .masterRst(masterRst), .start(start), .cfgWe(cfgWe),
    .cfgAddr(cfgAddr), .cfgField(cfgField), .cfgData(cfgData),
    .stumpsDone(stumpsDone), .MISR1_Out(MISR1_Out), .MISR2_Out(MISR2_Out),
    .sessRst(sessRst), .PRPG1_Poly(PRPG1_Poly), .PRPG2_Poly(PRPG2_Poly),
    .MISR1_Poly(MISR1_Poly), .MISR2_Poly(MISR2_Poly), .cfgIdx(cfgIdx),
    .busy(busy), .done(done), .pass(pass), .failMap(failMap),
    .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shadow table
  logic [15:0] t_p1 [N];
  logic [11:0] t_p2 [N];
  logic [15:0] t_m1 [N];
  logic [11:0] t_m2 [N];
  logic [15:0] t_g1 [N];
  logic [11:0] t_g2 [N];

  // STUMPS model controls and state
  int  len [N];
  bit  never [N];
  int  hold_cyc = 0;
  int  m_cnt = 0, m_hold = 0;
  bit  m_active = 0, m_never = 0;
  logic [15:0] m_sig1 = '0;
  logic [11:0] m_sig2 = '0;
  int  cyc = 0, pulses = 0, wide = 0;
  bit  prev_sr = 0;
  int  pulse_cyc [$];

  // Behavioural STUMPS signatures as a function of the session polynomials
  function automatic logic [15:0] sig1(logic [15:0] p1, logic [11:0] p2, logic [15:0] m1);
    return ((p1 * 16'd3) ^ m1 ^ {p2, 4'h0}) + 16'h1234;
  endfunction

  function automatic logic [11:0] sig2(logic [11:0] p2, logic [11:0] m2, logic [15:0] p1);
    return (p2 ^ (m2 * 12'd5)) + p1[11:0] + 12'h0a5;
  endfunction

  // Expected fail map: timeout entries plus entries whose golden pair
  // differs from what the STUMPS model will produce
  function automatic logic [N-1:0] exp_map();
    logic [N-1:0] m;
    m = '0;
    for (int e = 0; e < N; e++)
      if (never[e] || t_g1[e] != sig1(t_p1[e], t_p2[e], t_m1[e]) ||
          t_g2[e] != sig2(t_p2[e], t_m2[e], t_p1[e]))
        m[e] = 1'b1;
    return m;
  endfunction

  // STUMPS controller model plus sessRst pulse monitor (negedge driven)
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (sessRst) begin
        pulses++;
        pulse_cyc.push_back(cyc);
        if (prev_sr) wide++;
      end
      prev_sr = sessRst;
      if (masterRst) begin
        stumpsDone = 1'b0;
        m_active   = 0;
      end else if (sessRst) begin
        m_sig1   = sig1(PRPG1_Poly, PRPG2_Poly, MISR1_Poly);
        m_sig2   = sig2(PRPG2_Poly, MISR2_Poly, PRPG1_Poly);
        m_cnt    = len[cfgIdx];
        m_never  = never[cfgIdx];
        m_hold   = hold_cyc;
        m_active = 1;
        MISR1_Out = ~m_sig1;
        MISR2_Out = ~m_sig2;
        if (m_hold == 0) stumpsDone = 1'b0;
      end else if (m_active) begin
        if (m_hold > 0) begin
          m_hold--;
          if (m_hold == 0) stumpsDone = 1'b0;
        end else if (!m_never) begin
          if (m_cnt > 0) m_cnt--;
          else begin
            MISR1_Out  = m_sig1;
            MISR2_Out  = m_sig2;
            stumpsDone = 1'b1;
            m_active   = 0;
          end
        end
      end
    end
  end

  task automatic wr(input int a, input int f, input logic [15:0] d);
    cfgWe = 1'b1; cfgAddr = 2'(a); cfgField = 3'(f); cfgData = d;
    @(negedge clk);
    cfgWe = 1'b0;
    case (f)
      0: t_p1[a] = d;
      1: t_p2[a] = d[11:0];
      2: t_m1[a] = d;
      3: t_m2[a] = d[11:0];
      4: t_g1[a] = d;
      5: t_g2[a] = d[11:0];
      default: ;
    endcase
  endtask

  task automatic load_entry(input int a);
    logic [15:0] p1, m1;
    logic [11:0] p2, m2;
    p1 = 16'($urandom); p2 = 12'($urandom);
    m1 = 16'($urandom); m2 = 12'($urandom);
    wr(a, 0, p1);
    wr(a, 1, {4'($urandom), p2});
    wr(a, 2, m1);
    wr(a, 3, {4'($urandom), m2});
    wr(a, 4, sig1(p1, p2, m1));
    wr(a, 5, {4'($urandom), sig2(p2, m2, p1)});
    len[a]   = $urandom_range(40, 2);
    never[a] = 0;
  endtask

  task automatic go();
    pulses = 0; wide = 0; pulse_cyc.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 20000; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (failMap !== '0) begin errors++; $display("FAIL reset_failmap got %b want 0000", failMap); end
    checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_timeouterr got %b want 0", timeoutErr); end
    checks++; if (sessRst !== 1'b0) begin errors++; $display("FAIL reset_sessrst got %b want 0", sessRst); end
    checks++; if (cfgIdx !== '0) begin errors++; $display("FAIL reset_cfgidx got %0d want 0", cfgIdx); end
    checks++;
    if ({PRPG1_Poly, PRPG2_Poly, MISR1_Poly, MISR2_Poly} !== 56'd0) begin
      errors++; $display("FAIL reset_polys got %h want 0", {PRPG1_Poly, PRPG2_Poly, MISR1_Poly, MISR2_Poly});
    end
    masterRst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_all_pass();
    bit ok;
    for (int e = 0; e < N; e++) load_entry(e);
    wr(0, 6, 16'($urandom));
    wr(1, 7, 16'($urandom));
    go();
    checks++; if (busy !== 1'b1 || sessRst !== 1'b0) begin errors++; $display("FAIL cycle1_load busy=%b sessRst=%b want 1/0", busy, sessRst); end
    @(negedge clk);
    checks++; if (sessRst !== 1'b1) begin errors++; $display("FAIL cycle2_sessrst got %b want 1", sessRst); end
    checks++; if (PRPG1_Poly !== t_p1[0] || MISR2_Poly !== t_m2[0]) begin errors++; $display("FAIL cycle2_polys got %h/%h want %h/%h", PRPG1_Poly, MISR2_Poly, t_p1[0], t_m2[0]); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL all_pass_done got timeout want done"); end
    checks++; if (failMap !== exp_map()) begin errors++; $display("FAIL all_pass_failmap got %b want %b", failMap, exp_map()); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL all_pass_pass got %b want 1", pass); end
    checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL all_pass_timeouterr got %b want 0", timeoutErr); end
    checks++; if (pulses !== N || wide !== 0) begin errors++; $display("FAIL all_pass_pulses got %0d (wide %0d) want %0d (0)", pulses, wide, N); end
    checks++; if (PRPG2_Poly !== t_p2[N-1] || busy !== 1'b0) begin errors++; $display("FAIL all_pass_final got poly %h busy %b want %h 0", PRPG2_Poly, busy, t_p2[N-1]); end
    $display("test_all_pass failMap=%b pass=%b pulses=%0d", failMap, pass, pulses);
  endtask

  task automatic test_golden_miss();
    bit ok;
    logic [11:0] keep, bad;
    keep = t_g2[2];
    bad  = keep ^ (12'h001 << $urandom_range(11, 0));
    wr(2, 5, {4'h0, bad});
    go();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL golden_miss_done got timeout want done"); end
    checks++; if (failMap !== exp_map()) begin errors++; $display("FAIL golden_miss_failmap got %b want %b", failMap, exp_map()); end
    checks++; if (pass !== (exp_map() == '0)) begin errors++; $display("FAIL golden_miss_pass got %b want %b", pass, exp_map() == '0); end
    checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL golden_miss_timeouterr got %b want 0", timeoutErr); end
    $display("test_golden_miss failMap=%b pass=%b", failMap, pass);
    wr(2, 5, {4'h0, keep});
  endtask

  task automatic test_timeout();
    bit ok;
    int gap;
    never[1] = 1;
    go();
    wait_done(ok);
    gap = (pulse_cyc.size() >= 3) ? pulse_cyc[2] - pulse_cyc[1] : -1;
    checks++; if (!ok) begin errors++; $display("FAIL timeout_done got timeout want done"); end
    checks++; if (failMap !== exp_map()) begin errors++; $display("FAIL timeout_failmap got %b want %b", failMap, exp_map()); end
    checks++; if (timeoutErr !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", timeoutErr); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL timeout_pass got %b want 0", pass); end
    checks++; if (pulses !== N) begin errors++; $display("FAIL timeout_pulses got %0d want %0d", pulses, N); end
    // RST + TO RUN cycles + CHECK + LOAD separate the two session pulses
    checks++; if (gap !== TO + 3) begin errors++; $display("FAIL timeout_run_len got %0d want %0d", gap, TO + 3); end
    $display("test_timeout failMap=%b timeoutErr=%b gap=%0d", failMap, timeoutErr, gap);
    never[1] = 0;
  endtask

  task automatic test_done_held();
    bit ok;
    hold_cyc = 3;
    go();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_done got timeout want done"); end
    checks++; if (failMap !== exp_map()) begin errors++; $display("FAIL held_failmap got %b want %b", failMap, exp_map()); end
    checks++; if (pulses !== N) begin errors++; $display("FAIL held_pulses got %0d want %0d", pulses, N); end
    $display("test_done_held failMap=%b pulses=%0d", failMap, pulses);
    hold_cyc = 0;
  endtask

  task automatic test_busy_ignore();
    bit ok;
    logic [15:0] np1;
    go();
    repeat (10) @(negedge clk);
    cfgWe = 1'b1; cfgAddr = 2'd3; cfgField = 3'd4; cfgData = ~t_g1[3]; start = 1'b1;
    @(negedge clk);
    cfgWe = 1'b0; start = 1'b0;
    wait_done(ok);
    checks++; if (!ok || pulses !== N) begin errors++; $display("FAIL busy_start_ignored got done=%b pulses=%0d want 1/%0d", ok, pulses, N); end
    checks++; if (failMap !== exp_map()) begin errors++; $display("FAIL busy_run_failmap got %b want %b", failMap, exp_map()); end
    go();
    wait_done(ok);
    checks++; if (failMap !== exp_map()) begin errors++; $display("FAIL busy_write_ignored got %b want %b", failMap, exp_map()); end
    // Same-cycle write and start: the new PRPG1 value must be used
    np1 = 16'($urandom);
    wr(0, 4, sig1(np1, t_p2[0], t_m1[0]));
    wr(0, 5, {4'h0, sig2(t_p2[0], t_m2[0], np1)});
    pulses = 0; wide = 0; pulse_cyc.delete();
    cfgWe = 1'b1; cfgAddr = 2'd0; cfgField = 3'd0; cfgData = np1; start = 1'b1;
    @(negedge clk);
    cfgWe = 1'b0; start = 1'b0;
    t_p1[0] = np1;
    @(negedge clk);
    checks++; if (PRPG1_Poly !== np1) begin errors++; $display("FAIL write_start_poly got %h want %h", PRPG1_Poly, np1); end
    wait_done(ok);
    checks++; if (!ok || failMap !== exp_map()) begin errors++; $display("FAIL write_start_failmap got %b want %b", failMap, exp_map()); end
    $display("test_busy_ignore failMap=%b pulses=%0d", failMap, pulses);
  endtask

  task automatic test_midrun_reset();
    bit ok, found;
    for (int e = 0; e < N; e++) load_entry(e);
    wr(0, 4, ~t_g1[0]);
    len[3] = 40;
    go();
    found = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sessRst === 1'b1 && cfgIdx === 2'd3) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrun_reach_entry3 got no session want session 3"); end
    repeat (3) @(negedge clk);
    masterRst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, timeoutErr, sessRst} !== 5'b0 || failMap !== '0 || cfgIdx !== '0) begin
      errors++; $display("FAIL midrun_reset_outputs got busy%b done%b pass%b terr%b srst%b map%b idx%0d want all 0",
                         busy, done, pass, timeoutErr, sessRst, failMap, cfgIdx);
    end
    checks++; if (PRPG1_Poly !== '0 || MISR1_Poly !== '0) begin errors++; $display("FAIL midrun_reset_polys got %h/%h want 0", PRPG1_Poly, MISR1_Poly); end
    for (int e = 0; e < N; e++) begin
      t_p1[e] = '0; t_p2[e] = '0; t_m1[e] = '0; t_m2[e] = '0; t_g1[e] = '0; t_g2[e] = '0;
      len[e] = 5; never[e] = 0;
    end
    @(negedge clk);
    masterRst = 1'b0;
    @(negedge clk);
    go();
    @(negedge clk);
    checks++; if (sessRst !== 1'b1 || PRPG1_Poly !== '0) begin errors++; $display("FAIL empty_table_poly got srst %b poly %h want 1 0000", sessRst, PRPG1_Poly); end
    wait_done(ok);
    checks++; if (!ok || failMap !== exp_map()) begin errors++; $display("FAIL empty_table_failmap got %b want %b", failMap, exp_map()); end
    checks++; if (pass !== (exp_map() == '0)) begin errors++; $display("FAIL empty_table_pass got %b want %b", pass, exp_map() == '0); end
    $display("test_midrun_reset failMap=%b pass=%b", failMap, pass);
  endtask

  initial begin
    for (int e = 0; e < N; e++) begin
      t_p1[e] = '0; t_p2[e] = '0; t_m1[e] = '0; t_m2[e] = '0; t_g1[e] = '0; t_g2[e] = '0;
      len[e] = 5; never[e] = 0;
    end
    test_reset();
    test_all_pass();
    test_golden_miss();
    test_timeout();
    test_done_held();
    test_busy_ignore();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
